// File: rtl/sp_octet_loader.sv
// Tile staging loader for the sparse octet: assembles beat-serial tiles into a two-bank
// ping-pong store and replays each tile into the octet aligned to its fetch phase.
module sp_octet_loader #(
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned IdxWidth    = 32,
  parameter int unsigned ABeats      = 2,
  parameter int unsigned BBeats      = 2,
  parameter int unsigned CBeats      = 8,
  // Reset value of the replayed-tile counter; nonzero only to exercise wrap-around.
  parameter logic [15:0] TilesRstVal = 16'h0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic [IdxWidth-1:0]  in_idx_i,
  input  logic                 octet_idle_i,
  input  logic                 octet_fetch_i,
  output logic                 start_o,
  output logic                 fetch_done_o,
  output logic [DataWidth-1:0] a_data_o,
  output logic [DataWidth-1:0] b_data_o,
  output logic [DataWidth-1:0] c_data_o,
  output logic [IdxWidth-1:0]  weight_idx_o,
  output logic [15:0]          tiles_done_o
);

  localparam int unsigned TileBeats = ABeats + BBeats + CBeats;
  localparam int unsigned WrCntW    = $clog2(TileBeats);
  localparam int unsigned RdCntW    = (CBeats > 1) ? $clog2(CBeats) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StFetch} rd_state_e;

  // Tile storage: beats laid out A, B, C in stream order within each bank.
  logic [DataWidth-1:0] mem_q [2][TileBeats];
  logic [IdxWidth-1:0]  idx_q [2];

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [15:0]       tiles_q, tiles_d;
  rd_state_e         state_q, state_d;

  logic              wr_fire, wr_last;
  logic              fetch_act, fetch_last;
  logic              rd_release;
  logic [WrCntW-1:0] rd_pos_a, rd_pos_b, rd_pos_c;

  // ---------------- Write side ----------------
  assign in_ready_o = ~full_q[wr_bank_q];
  assign wr_fire    = in_valid_i & ~full_q[wr_bank_q];
  assign wr_last    = wr_fire & (wr_cnt_q == WrCntW'(TileBeats - 1));

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_last) begin
      wr_cnt_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + WrCntW'(1);
    end
  end

  // Release and fill completion always target different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (rd_release) full_d[rd_bank_q] = 1'b0;
    if (wr_last)    full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_bank_q][wr_cnt_q] <= in_data_i;
  end

  // ---------------- Read side ----------------
  // The first octet_fetch cycle is seen while still in StWait; it carries beat 0.
  assign fetch_act  = octet_fetch_i & ((state_q == StWait) | (state_q == StFetch));
  assign fetch_last = fetch_act & (rd_cnt_q == RdCntW'(CBeats - 1));
  assign rd_release = fetch_last;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    tiles_d   = tiles_q;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q] && octet_idle_i) state_d = StStart;
      end
      StStart: begin
        state_d = StWait;
      end
      StWait, StFetch: begin
        if (fetch_last) begin
          state_d   = StIdle;
          rd_cnt_d  = '0;
          rd_bank_d = ~rd_bank_q;
          tiles_d   = tiles_q + 16'd1;
        end else if (fetch_act) begin
          state_d  = StFetch;
          rd_cnt_d = rd_cnt_q + RdCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      tiles_q   <= TilesRstVal;
      idx_q[0]  <= '0;
      idx_q[1]  <= '0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      tiles_q   <= tiles_d;
      if (wr_fire && (wr_cnt_q == '0)) idx_q[wr_bank_q] <= in_idx_i;
    end
  end

  // ---------------- Output decode ----------------
  assign rd_pos_a = WrCntW'(rd_cnt_q);
  assign rd_pos_b = WrCntW'(ABeats) + WrCntW'(rd_cnt_q);
  assign rd_pos_c = WrCntW'(ABeats + BBeats) + WrCntW'(rd_cnt_q);

  always_comb begin
    a_data_o     = '0;
    b_data_o     = '0;
    c_data_o     = '0;
    weight_idx_o = '0;
    if (fetch_act) begin
      if (32'(rd_cnt_q) < ABeats) a_data_o = mem_q[rd_bank_q][rd_pos_a];
      if (32'(rd_cnt_q) < BBeats) b_data_o = mem_q[rd_bank_q][rd_pos_b];
      c_data_o = mem_q[rd_bank_q][rd_pos_c];
    end
    if ((state_q == StWait) || (state_q == StFetch)) weight_idx_o = idx_q[rd_bank_q];
  end

  assign start_o      = (state_q == StStart);
  assign fetch_done_o = fetch_last;
  assign tiles_done_o = tiles_q;

endmodule

// File: doc/sp_octet_loader.md
# sp_octet_loader

Tile staging and sequencing stage directly upstream of the sparse octet. It accepts one beat-serial operand stream (compressed weights plus indices, activations, accumulator tile), assembles complete tiles in a two-bank ping-pong store, and replays each tile into the octet. Replay is cycle-aligned to the octet's fetch phase, and the loader generates the octet's `start` and `fetch_done` handshakes. While one bank is replayed, the next tile fills the other bank.

## Interface
- `DATA_WIDTH`, 128: width of A/B/C beats and of the input stream.
- `IDX_WIDTH`, 32: weight-index word width (four 8-bit indices).
- `A_BEATS`, 2: A beats per tile.
- `B_BEATS`, 2: B beats per tile.
- `C_BEATS`, 8: C beats per tile; also the fetch-phase length. Must be ≥ `A_BEATS` and ≥ `B_BEATS`.
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst`, in, 1: asynchronous, active-low reset (asserted at 0).
- `in_valid`, in, 1: stream beat valid.
- `in_ready`, out, 1: stream beat accepted when `in_valid && in_ready`.
- `in_data`, in, `DATA_WIDTH`: stream beat payload.
- `in_idx`, in, `IDX_WIDTH`: weight indices; sampled only on tile beat 0.
- `octet_idle`, in, 1: octet idle status.
- `octet_fetch`, in, 1: octet fetch-phase status.
- `start`, out, 1: one-cycle tile start pulse to the octet.
- `fetch_done`, out, 1: to the octet; high in the last fetch cycle of a tile.
- `a_data_out`, out, `DATA_WIDTH`: to octet `a_data_in`.
- `b_data_out`, out, `DATA_WIDTH`: to octet `b_data_in`.
- `c_data_out`, out, `DATA_WIDTH`: to octet `c_data_in`.
- `weight_idx_out`, out, `IDX_WIDTH`: to octet `weight_idx_in`.
- `tiles_done`, out, 16: count of tiles fully replayed; wraps 0xFFFF→0.

## Operation
- Tile format is `T = A_BEATS + B_BEATS + C_BEATS` beats, 12 at default parameters.
  - Beats 0..A_BEATS-1 are A; `in_idx` is captured on beat 0.
  - The next B_BEATS beats are B.
  - The remaining C_BEATS beats are C.
- Each bank (0, 1) has storage for one tile plus one index word and a `full` flag.
- Write side:
  - `wr_bank` (reset 0) and beat counter `wr_cnt` (0..T-1).
  - `in_ready = !full[wr_bank]`.
  - On each accepted beat, store at position `wr_cnt` and increment `wr_cnt`.
  - On beat T-1: set `full[wr_bank]`, clear `wr_cnt`, toggle `wr_bank`.
- Read side FSM with `rd_bank` (reset 0) and counter `rd_cnt` (0..C_BEATS-1):
  - R_IDLE: if `full[rd_bank] && octet_idle`, go to R_START.
  - R_START: `start`=1 for exactly this cycle, then go to R_WAIT.
  - R_WAIT: hold until `octet_fetch`=1, then go to R_FETCH with `rd_cnt`=0 in that same cycle.
  - R_FETCH: presents beat `rd_cnt` each cycle `octet_fetch`=1, then increments `rd_cnt`.
    - If `octet_fetch` drops, hold `rd_cnt` and force data outputs to 0 (stall).
    - When `rd_cnt == C_BEATS-1` and `octet_fetch`: `fetch_done`=1 in that cycle. On the next edge, clear `full[rd_bank]`, toggle `rd_bank`, increment `tiles_done`, and go to R_IDLE.
- Data presentation, only in R_FETCH with `octet_fetch`=1 (all other times 0):
  - `a_data_out` = A[rd_cnt] if `rd_cnt < A_BEATS`, else 0.
  - `b_data_out` = B[rd_cnt] if `rd_cnt < B_BEATS`, else 0.
  - `c_data_out` = C[rd_cnt].
  - `weight_idx_out` = bank index word for the entire R_WAIT and R_FETCH span.
- A bank being filled is never the bank being replayed; `full` gates both sides.
- Same-cycle release of one bank and fill completion of the other are independent and both take effect.
- If the write side is blocked on a full bank, `in_ready` rises in the cycle after release.

## Timing
- Reset (`rst`=0, asynchronous):
  - Outputs: `in_ready`=1; `start`=0; `fetch_done`=0; all data/idx outputs 0; `tiles_done`=0.
  - State: FSM in R_IDLE; banks empty; `wr_bank`=0, `rd_bank`=0; counters 0.
  - Reset mid-tile discards partial and full tiles.
- Decode is from registered state; `fetch_done` and data outputs are combinational from `rd_cnt`, state and `octet_fetch`, with no added latency.
- Minimum latency from the last input beat of a tile (bank empty, FSM in R_IDLE, `octet_idle`=1) to `start`: 2 cycles.
  - Edge 1 sets `full`.
  - Edge 2 enters R_START.
- Fetch phase is exactly C_BEATS `octet_fetch` cycles per tile when not stalled.
- Sustained input rate is 1 beat/cycle until both banks are full.

## Test plan
- Single tile, default parameters: 12 beats with A0=0x11…, A1=0x22…, idx=0x04030201 → one `start` pulse; during 8 fetch cycles `a_data_out` = A0, A1, then 0×6; `c_data_out` = C0..C7 in order; `fetch_done` only in fetch cycle 8; `tiles_done`=1.
- Back-to-back: 3 tiles streamed continuously with octet slow → `in_ready`=0 after tile 2 completes, rises the cycle after tile 1's `fetch_done`; replay order is tile 1, 2, 3 with bank alternation 0,1,0.
- Fetch stall: drop `octet_fetch` for 3 cycles at `rd_cnt`=4 → outputs 0 during the stall; resume with C4; `fetch_done` delayed 3 cycles.
- Start gating: full bank with `octet_idle`=0 → no `start` until `octet_idle`=1, then exactly one pulse.
- Reset mid-fetch at `rd_cnt`=5 → all outputs 0 immediately; after release, a new tile replays from beat 0; `tiles_done`=0.
- Counter wrap: preload or run 65536 tiles → `tiles_done` goes 0xFFFF→0x0000.
